march_patgen: RTL and testbench

- Parametrised deterministic BIST pattern generator; the next generation of the single-pattern patgen.
- Drives the patgen side of bist_if: addr, data, check, wmask, we, re, done.
- Runs the selected test algorithm (March C- over multiple data backgrounds, zero-one, or checkerboard) over addresses 0..MAX_ADDR-1.
- Issues one memory operation per enabled cycle. Response comparison is downstream.

---
 rtl/march_patgen.sv | 232 +++++++++++++++++++++++
 tb/tb_march_patgen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/march_patgen.sv
// march_patgen: deterministic BIST pattern generator (patgen side of bist_if).
// It runs March C- over three data backgrounds, zero-one or checkerboard
// across addresses 0..MAX_ADDR-1, and issues one memory op per enabled edge.
// Response comparison happens downstream.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset, has priority over en
//   en           advance enable, one operation per enabled edge
//   pattern_sel  0 = March C- enhanced, 1 = zero-one, 2 = checkerboard;
//                any other code is unsupported
//   addr         memory address of the current op
//   data         pattern value of the current op (write data)
//   check        expected read data of the current op
//   wmask        write mask, all ones on every op
//   we / re      write / read strobe, exactly one of them per op
//   done         sticky test-complete flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | after reset; the first enabled edge latches pattern_sel
// S_RUN  | one op presented per enabled edge
// S_DONE | sequence finished or pattern unsupported; left only by rst
module march_patgen #(
  parameter int MAX_ADDR   = 32,
  parameter int ADDR_WIDTH = (MAX_ADDR > 1) ? $clog2(MAX_ADDR) : 1,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            pattern_sel,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] check,
  output logic [MASK_WIDTH-1:0] wmask,
  output logic                  we,
  output logic                  re,
  output logic                  done
);

  localparam logic [3:0] SEL_MARCH = 4'd0;
  localparam logic [3:0] SEL_CB    = 4'd2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ADDR - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]            r_mode;
  logic [2:0]            r_elem;
  logic                  r_opi;
  logic [1:0]            r_bg;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic [3:0]            w_mode;
  logic                  w_is_march;
  logic                  w_supported;
  logic [2:0]            w_last_elem;
  logic [1:0]            w_last_bg;
  logic [5:0]            w_cur_rom;
  logic [5:0]            w_inc_rom;
  logic [5:0]            w_nxt_rom;
  logic [2:0]            w_nxt_elem;
  logic                  w_nxt_opi;
  logic [1:0]            w_nxt_bg;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic                  w_at_last;
  logic                  w_op_wr;
  logic                  w_op_one;
  logic [1:0]            w_bg_sel;
  logic [DATA_WIDTH-1:0] w_bg_word;
  logic [DATA_WIDTH-1:0] w_val;
  logic                  w_load;
  logic                  w_finish;

  // Element ROM entry: {down, two_ops, op0_wr, op0_one, op1_wr, op1_one}
  function automatic logic [5:0] elem_rom(input logic march, input logic [2:0] e);
    logic [5:0] r;
    r = 6'b0;
    if (march) begin
      case (e)
        3'd0:    r = 6'b0_0_1_0_0_0;  // up(w0)
        3'd1:    r = 6'b0_1_0_0_1_1;  // up(r0,w1)
        3'd2:    r = 6'b0_1_0_1_1_0;  // up(r1,w0)
        3'd3:    r = 6'b1_1_0_0_1_1;  // down(r0,w1)
        3'd4:    r = 6'b1_1_0_1_1_0;  // down(r1,w0)
        default: r = 6'b0_0_0_0_0_0;  // up(r0)
      endcase
    end else begin
      case (e)
        3'd0:    r = 6'b0_0_1_0_0_0;  // up(w0)
        3'd1:    r = 6'b0_0_0_0_0_0;  // up(r0)
        3'd2:    r = 6'b0_0_1_1_0_0;  // up(w1)
        default: r = 6'b0_0_0_1_0_0;  // up(r1)
      endcase
    end
    return r;
  endfunction

  // In IDLE the mode is not latched yet, so op 0 is decoded from the live input.
  assign w_mode      = (r_state == S_IDLE) ? pattern_sel : r_mode;
  assign w_is_march  = (w_mode == SEL_MARCH);
  assign w_supported = (w_mode <= SEL_CB);
  assign w_last_elem = w_is_march ? 3'd5 : 3'd3;
  assign w_last_bg   = w_is_march ? 2'd2 : 2'd0;
  assign w_cur_rom   = elem_rom(w_is_march, r_elem);
  assign w_inc_rom   = elem_rom(w_is_march, 3'(r_elem + 3'd1));

  // Position of the op after the one currently presented.
  always_comb begin
    w_nxt_elem = r_elem;
    w_nxt_opi  = r_opi;
    w_nxt_bg   = r_bg;
    w_nxt_addr = r_addr;
    w_at_last  = 1'b0;
    if (r_state == S_IDLE) begin
      w_nxt_elem = 3'd0;
      w_nxt_opi  = 1'b0;
      w_nxt_bg   = 2'd0;
      w_nxt_addr = '0;
    end else if (!r_opi && w_cur_rom[4]) begin
      w_nxt_opi = 1'b1;
    end else begin
      w_nxt_opi = 1'b0;
      if (w_cur_rom[5] ? (r_addr != '0) : (r_addr != LAST_ADDR)) begin
        w_nxt_addr = w_cur_rom[5] ? r_addr - 1'b1 : r_addr + 1'b1;
      end else if (r_elem != w_last_elem) begin
        w_nxt_elem = 3'(r_elem + 3'd1);
        w_nxt_addr = w_inc_rom[5] ? LAST_ADDR : '0;
      end else if (r_bg != w_last_bg) begin
        w_nxt_bg   = 2'(r_bg + 2'd1);
        w_nxt_elem = 3'd0;
        w_nxt_addr = '0;
      end else begin
        w_at_last = 1'b1;
      end
    end
  end

  assign w_nxt_rom = elem_rom(w_is_march, w_nxt_elem);
  assign w_op_wr   = w_nxt_opi ? w_nxt_rom[1] : w_nxt_rom[3];
  assign w_op_one  = w_nxt_opi ? w_nxt_rom[0] : w_nxt_rom[2];
  assign w_bg_sel  = w_is_march ? w_nxt_bg : ((w_mode == SEL_CB) ? 2'd2 : 2'd0);

  always_comb begin
    w_bg_word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      case (w_bg_sel)
        2'd1:    w_bg_word[i] = i[0];
        2'd2:    w_bg_word[i] = i[0] ^ w_nxt_addr[0];
        default: w_bg_word[i] = 1'b0;
      endcase
    end
  end

  assign w_val = w_op_one ? ~w_bg_word : w_bg_word;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          if (w_supported) begin
            w_state_nxt = S_RUN;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_finish    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (en) begin
          if (w_at_last) begin
            w_state_nxt = S_DONE;
            w_finish    = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 4'd0;
      r_elem <= 3'd0;
      r_opi  <= 1'b0;
      r_bg   <= 2'd0;
      r_addr <= '0;
      addr   <= '0;
      data   <= '0;
      check  <= '0;
      wmask  <= '0;
      we     <= 1'b0;
      re     <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && en) r_mode <= pattern_sel;
      if (w_load) begin
        r_elem <= w_nxt_elem;
        r_opi  <= w_nxt_opi;
        r_bg   <= w_nxt_bg;
        r_addr <= w_nxt_addr;
        addr   <= w_nxt_addr;
        data   <= w_val;
        check  <= w_val;
        wmask  <= '1;
        we     <= w_op_wr;
        re     <= ~w_op_wr;
      end else if (w_finish) begin
        wmask <= '0;
        we    <= 1'b0;
        re    <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_march_patgen.sv
// Testbench for march_patgen (N=4, 8-bit data). Stimulus pushes the expected
// op sequence into a queue; an independent monitor pops and compares on every
// enabled edge and checks that outputs hold on disabled edges.
module tb_march_patgen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] pattern_sel;
  logic [1:0] addr;
  logic [7:0] data;
  logic [7:0] check;
  logic [3:0] wmask;
  logic       we;
  logic       re;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         is_done;
    logic [1:0] a;
    logic [7:0] d;
    bit         w;
    int         edges;
  } exp_t;

  exp_t exp_q[$];

  march_patgen #(.MAX_ADDR(4), .DATA_WIDTH(8), .MASK_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .addr(addr), .data(data), .check(check), .wmask(wmask),
    .we(we), .re(re), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_op(input logic [1:0] a, input logic [7:0] d, input bit w);
    exp_t e;
    e.is_done = 1'b0; e.a = a; e.d = d; e.w = w; e.edges = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int edges);
    exp_t e;
    e.is_done = 1'b1; e.a = 2'd0; e.d = 8'd0; e.w = 1'b0; e.edges = edges;
    exp_q.push_back(e);
  endtask

  task automatic load_zero_one();
    for (int k = 0; k < 16; k++)
      push_op(2'(k % 4), (k < 8) ? 8'h00 : 8'hFF, (k < 4) || (k >= 8 && k < 12));
    push_done(17);
  endtask

  task automatic load_checker();
    logic [7:0] cb0 [4];
    cb0 = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    for (int k = 0; k < 16; k++) begin
      int el;
      el = k / 4;
      push_op(2'(k % 4), (el < 2) ? cb0[k % 4] : ~cb0[k % 4], (el == 0) || (el == 2));
    end
    push_done(17);
  endtask

  function automatic logic [7:0] bg_word(input int bg, input int a);
    if (bg == 0) return 8'h00;
    if (bg == 1) return 8'hAA;
    return (a % 2 == 0) ? 8'hAA : 8'h55;
  endfunction

  // March C-: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 dn(r0,w1) M4 dn(r1,w0) M5 up(r0)
  task automatic load_march();
    bit down [6];
    int nops [6];
    bit wr0 [6];
    bit one0 [6];
    down = '{0, 0, 0, 1, 1, 0};
    nops = '{1, 2, 2, 2, 2, 1};
    wr0  = '{1, 0, 0, 0, 0, 0};
    one0 = '{0, 0, 1, 0, 1, 0};
    for (int bg = 0; bg < 3; bg++)
      for (int e = 0; e < 6; e++)
        for (int j = 0; j < 4; j++) begin
          int a;
          logic [7:0] b;
          a = down[e] ? 3 - j : j;
          b = bg_word(bg, a);
          push_op(2'(a), one0[e] ? ~b : b, wr0[e]);
          // second op of two-op elements is always a write of the opposite value
          if (nops[e] == 2) push_op(2'(a), one0[e] ? b : ~b, 1'b1);
        end
    push_done(121);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [24:0] cur;
    logic [24:0] prev;
    logic [24:0] want;
    logic        s_en;
    logic        s_rst;
    int          edges;
    exp_t        e;
    prev  = '0;
    edges = 0;
    forever begin
      @(posedge clk);
      s_en  = en;
      s_rst = rst;
      @(negedge clk);
      cur = {addr, data, check, wmask, we, re, done};
      if (s_rst) begin
        edges = 0;
      end else if (!s_en) begin
        n_checks++;
        if (cur !== prev) begin
          n_errors++;
          $display("FAIL hold: got %h want %h", cur, prev);
        end
      end else begin
        edges++;
        if (done && !prev[0]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL done_unexpected: got done at edge %0d, want no done", edges);
          end else begin
            e = exp_q.pop_front();
            if (!e.is_done) begin
              n_errors++;
              $display("FAIL done_early: got done at edge %0d, want op addr %0d data %h", edges, e.a, e.d);
            end else if ({we, re, wmask} !== 6'b0 || edges != e.edges || cur[24:7] !== prev[24:7]) begin
              n_errors++;
              $display("FAIL done_state: got we%b re%b wmask%h edge %0d out %h, want 0 0 0 edge %0d out %h",
                       we, re, wmask, edges, cur[24:7], e.edges, prev[24:7]);
            end
          end
        end else if (done) begin
          n_checks++;
          if (cur !== prev) begin
            n_errors++;
            $display("FAIL done_sticky: got %h want %h", cur, prev);
          end
        end else begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL op_unexpected: got addr %0d data %h we%b re%b, want nothing", addr, data, we, re);
          end else begin
            e = exp_q.pop_front();
            want = {e.a, e.d, e.d, 4'hF, e.w, ~e.w, 1'b0};
            if (e.is_done || cur !== want) begin
              n_errors++;
              $display("FAIL op: got %h want %h (done_expected=%0d)", cur, want, e.is_done);
            end
          end
        end
      end
      prev = cur;
    end
  end

  task automatic check_zero(input string name);
    n_checks++;
    if ({addr, data, check, wmask, we, re, done} !== 25'd0) begin
      n_errors++;
      $display("FAIL %s: got %h want 0", name, {addr, data, check, wmask, we, re, done});
    end
  endtask

  task automatic do_reset(input logic en_val);
    @(negedge clk); #1;
    rst = 1'b1;
    en  = en_val;
    @(posedge clk);
    @(negedge clk); #1;
    check_zero("reset_outputs");
    rst = 1'b0;
    en  = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_n(input int n);
    for (int c = 0; c < n; c++) begin
      en = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
    end
    en = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int max_cyc, input bit rnd,
                             input int chg_at, input logic [3:0] chg_sel);
    int cyc;
    cyc = 0;
    while (!done && cyc < max_cyc) begin
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == chg_at) pattern_sel = chg_sel;
      @(posedge clk);
      @(negedge clk); #1;
      cyc++;
    end
    en = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, want done=1", name, cyc);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_leftover: got %0d pending expectations, want 0", name, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    pattern_sel = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_zero("initial_reset");
    rst = 1'b0;

    pattern_sel = 4'd1;
    load_zero_one();
    run_to_done("zero_one", 100, 1'b0, -1, 4'd0);

    do_reset(1'b1);
    pattern_sel = 4'd2;
    load_checker();
    run_to_done("checker", 100, 1'b0, -1, 4'd0);

    do_reset(1'b0);
    pattern_sel = 4'd0;
    load_march();
    run_to_done("march", 300, 1'b0, -1, 4'd0);

    do_reset(1'b0);
    pattern_sel = 4'd0;
    load_march();
    run_to_done("march_rand_en", 1500, 1'b1, -1, 4'd0);

    do_reset(1'b0);
    pattern_sel = 4'd0;
    load_march();
    run_n(38);
    do_reset(1'b1);
    pattern_sel = 4'd1;
    load_zero_one();
    run_to_done("rerun_zero_one", 100, 1'b0, 5, 4'd2);

    do_reset(1'b0);
    pattern_sel = 4'hF;
    push_done(1);
    run_to_done("unsupported", 10, 1'b0, -1, 4'd0);
    run_n(5);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
